// File: rtl/stream_rx_if.sv
// stream_rx_if: handshake/bus bundle for stream_rx.
//   in_valid / in_data  : upstream beats of N signed 8-bit lanes (no backpressure)
//   out_valid / out_ready / out_data / out_lane / out_last : serial lane stream
// Modports: slave = the stream_rx block, master = the environment driving it.
interface stream_rx_if #(
  parameter int N = 4
);
  logic                  in_valid;
  logic [N*8-1:0]        in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_data;
  logic [$clog2(N)-1:0]  out_lane;
  logic                  out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_lane, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_lane, out_last
  );
endinterface

// File: rtl/stream_rx.sv
// stream_rx: receives N-lane beats into a DEPTH-entry FIFO and serializes them
// one signed 8-bit lane at a time with a valid/ready handshake.
// Ports:
//   clk      : single rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : stream_rx_if.slave (in_valid, in_data, out_valid, out_ready,
//              out_data, out_lane, out_last)
//   clr_ovf  : synchronous clear of the sticky overflow flag
//   overflow : sticky, set when a beat arrives while the FIFO is full
//   level    : FIFO occupancy 0..DEPTH, not counting the beat being serialized
//   out_sum  : (only with STREAM_RX_LANE_SUM_EN) signed sum of the N lanes of
//              the beat in the serializer, valid while out_last=1
// Optional feature macro: STREAM_RX_LANE_SUM_EN
module stream_rx #(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  stream_rx_if.slave                    bus,
  input  logic                          clr_ovf,
  output logic                          overflow,
  output logic [$clog2(DEPTH+1)-1:0]    level
`ifdef STREAM_RX_LANE_SUM_EN
  ,
  output logic signed [8+$clog2(N)-1:0] out_sum
`endif
);

  localparam int LW  = $clog2(N);
  localparam int AW  = $clog2(DEPTH);
  localparam int LVW = $clog2(DEPTH+1);
  localparam logic [LVW-1:0] FULL = LVW'(DEPTH);
  localparam logic [LW-1:0]  LAST = LW'(N-1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic [N*8-1:0]      beat_q, beat_d;
  logic [N*8-1:0]      mem [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LVW-1:0]      level_q, level_d;
  logic                ovf_q, ovf_d;
  logic [N*8-1:0]      head;
  logic                push, drop, pop;

  // Full test uses the registered level, so a pop on the same edge does not
  // make room for an incoming beat.
  always_comb begin
    push = bus.in_valid && (level_q != FULL);
    drop = bus.in_valid && (level_q == FULL);
    head = mem[rd_ptr_q];
  end

  // State register (plus serializer datapath registers)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic; pop is decided here because it is a transition side effect
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          beat_d  = head;
          lane_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (lane_q == LAST) begin
            lane_d = '0;
            if (level_q != '0) begin
              // back-to-back beats: reload without an idle bubble
              pop    = 1'b1;
              beat_d = head;
            end else begin
              state_d = IDLE;
            end
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_lane  = '0;
    bus.out_last  = 1'b0;
    if (state_q == SEND) begin
      bus.out_valid = 1'b1;
      bus.out_data  = beat_q[8*lane_q +: 8];
      bus.out_lane  = lane_q;
      bus.out_last  = (lane_q == LAST);
    end
  end

  // FIFO bookkeeping
  always_comb begin
    level_d = level_q;
    if (push && !pop)
      level_d = level_q + LVW'(1);
    else if (pop && !push)
      level_d = level_q - LVW'(1);
    // a drop takes priority over a clear on the same edge
    ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: pointers and level define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.in_data;
  end

  assign overflow = ovf_q;
  assign level    = level_q;

`ifdef STREAM_RX_LANE_SUM_EN
  localparam int SW = 8 + LW;
  logic signed [SW-1:0] sum_q, sum_d;

  // Sum of the head beat, captured when it enters the serializer
  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < N; i++)
      sum_d = sum_d + SW'($signed(head[8*i +: 8]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sum_q <= '0;
    else if (pop) sum_q <= sum_d;
  end

  assign out_sum = sum_q;
`endif

endmodule

// File: tb/tb_stream_rx.sv
module tb_stream_rx;
  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       overflow;
  logic [2:0] level;
`ifdef STREAM_RX_LANE_SUM_EN
  logic signed [9:0] out_sum;
`endif

  always #5 clk = ~clk;

  stream_rx_if #(.N(N)) bif ();

  stream_rx #(.N(N), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bif),
    .clr_ovf  (clr_ovf),
    .overflow (overflow),
    .level    (level)
`ifdef STREAM_RX_LANE_SUM_EN
    ,
    .out_sum  (out_sum)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [7:0] lane_byte(input int k, input int i);
    return 8'(k*16 + i);
  endfunction

  function automatic logic [31:0] mkbeat(input int k);
    logic [31:0] b;
    for (int i = 0; i < 4; i++) b[8*i +: 8] = lane_byte(k, i);
    return b;
  endfunction

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  el;
    logic        elast;
    logic [2:0]  elev;
    logic        eovf;
  } vec_t;

  vec_t tbl [6];

  logic [7:0] exp_q [$];
  logic       held_v;
  logic [7:0] held_d;
  logic [1:0] held_l;
  int         got;
  logic       found;

  initial begin
    // single beat 0x807F01FF, out_ready high throughout
    tbl[0] = '{1'b1, 32'h807F01FF, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'd1, 1'b0};
    tbl[1] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hFF, 2'd0, 1'b0, 3'd0, 1'b0};
    tbl[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h01, 2'd1, 1'b0, 3'd0, 1'b0};
    tbl[3] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h7F, 2'd2, 1'b0, 3'd0, 1'b0};
    tbl[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h80, 2'd3, 1'b1, 3'd0, 1'b0};
    tbl[5] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'd0, 1'b0};

    bif.in_valid  = 1'b0;
    bif.in_data   = '0;
    bif.out_ready = 1'b0;

    // reset values
    #12;
    chk("rst_valid", 32'(bif.out_valid), 0);
    chk("rst_data",  32'(bif.out_data), 0);
    chk("rst_lane",  32'(bif.out_lane), 0);
    chk("rst_last",  32'(bif.out_last), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf",   32'(overflow), 0);
    rst_n = 1'b1;
    tick();

    // table-driven single-beat serialization
    for (int i = 0; i < 6; i++) begin
      bif.in_valid  = tbl[i].iv;
      bif.in_data   = tbl[i].d;
      bif.out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("v%0d_valid", i), 32'(bif.out_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].elev));
      chk($sformatf("v%0d_ovf", i),   32'(overflow), 32'(tbl[i].eovf));
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_data", i), 32'(bif.out_data), 32'(tbl[i].ed));
        chk($sformatf("v%0d_lane", i), 32'(bif.out_lane), 32'(tbl[i].el));
        chk($sformatf("v%0d_last", i), 32'(bif.out_last), 32'(tbl[i].elast));
      end
    end
    bif.in_valid = 1'b0;

    // stalled fill: six beats, sixth dropped
    bif.out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      bif.in_valid = 1'b1;
      bif.in_data  = mkbeat(k);
      tick();
    end
    bif.in_valid = 1'b0;
    chk("fill_level", 32'(level), 4);
    chk("fill_ovf",   32'(overflow), 1);
    chk("fill_valid", 32'(bif.out_valid), 1);
    bif.out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      chk($sformatf("drain%0d_valid", j), 32'(bif.out_valid), 1);
      chk($sformatf("drain%0d_data", j),  32'(bif.out_data), 32'(lane_byte(j/4 + 1, j%4)));
      chk($sformatf("drain%0d_lane", j),  32'(bif.out_lane), 32'(j%4));
      tick();
    end
    chk("drain_idle",  32'(bif.out_valid), 0);
    chk("drain_level", 32'(level), 0);
    chk("drain_ovf",   32'(overflow), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);

    // clear coinciding with a drop: set wins
    bif.out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      bif.in_valid = 1'b1;
      bif.in_data  = mkbeat(k);
      tick();
    end
    chk("ovf_set", 32'(overflow), 1);
    bif.in_data = mkbeat(7);
    clr_ovf     = 1'b1;
    tick();
    chk("ovf_setwins", 32'(overflow), 1);
    chk("ovf_level",   32'(level), 4);
    bif.in_valid = 1'b0;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);
    do_reset();

    // reset during SEND lane 2 with level 3
    bif.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      bif.in_valid = 1'b1;
      bif.in_data  = mkbeat(k);
      tick();
    end
    bif.in_valid = 1'b0;
    chk("mid_level0", 32'(level), 3);
    bif.out_ready = 1'b1;
    tick();
    tick();
    chk("mid_lane2", 32'(bif.out_lane), 2);
    chk("mid_level", 32'(level), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bif.out_valid), 0);
    chk("arst_data",  32'(bif.out_data), 0);
    chk("arst_lane",  32'(bif.out_lane), 0);
    chk("arst_last",  32'(bif.out_last), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_ovf",   32'(overflow), 0);
    tick();
    rst_n = 1'b1;
    bif.in_valid = 1'b1;
    bif.in_data  = mkbeat(9);
    tick();
    bif.in_valid = 1'b0;
    chk("post_lat_valid", 32'(bif.out_valid), 0);
    chk("post_lat_level", 32'(level), 1);
    tick();
    chk("post_valid", 32'(bif.out_valid), 1);
    chk("post_lane",  32'(bif.out_lane), 0);
    chk("post_data",  32'(bif.out_data), 32'(lane_byte(9, 0)));
    chk("post_level", 32'(level), 0);
    for (int j = 0; j < 4; j++) tick();
    chk("post_idle", 32'(bif.out_valid), 0);

    // beats every 4 cycles, out_ready toggling; scoreboard with hold checks
    held_v = 1'b0;
    held_d = '0;
    held_l = '0;
    got    = 0;
    for (int c = 0; c < 80; c++) begin
      if (held_v) begin
        chk("hold_valid", 32'(bif.out_valid), 1);
        chk("hold_data",  32'(bif.out_data), 32'(held_d));
        chk("hold_lane",  32'(bif.out_lane), 32'(held_l));
        held_v = 1'b0;
      end
      bif.out_ready = (c % 2 == 0);
      bif.in_valid  = (c % 4 == 0) && (c < 16);
      bif.in_data   = mkbeat(10 + c/4);
      if (bif.in_valid)
        for (int i = 0; i < 4; i++) exp_q.push_back(lane_byte(10 + c/4, i));
      chk("tog_ovf", 32'(overflow), 0);
      if (bif.out_valid) begin
        if (bif.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("tog_extra", 32'(bif.out_valid), 0);
          end else begin
            chk("tog_data", 32'(bif.out_data), 32'(exp_q.pop_front()));
            chk("tog_lane", 32'(bif.out_lane), 32'(got % 4));
            chk("tog_last", 32'(bif.out_last), 32'(got % 4 == 3));
            got++;
          end
        end else begin
          held_v = 1'b1;
          held_d = bif.out_data;
          held_l = bif.out_lane;
        end
      end
      tick();
    end
    bif.in_valid = 1'b0;
    chk("tog_count", 32'(got), 16);

`ifdef STREAM_RX_LANE_SUM_EN
    do_reset();
    bif.out_ready = 1'b1;
    bif.in_valid  = 1'b1;
    bif.in_data   = 32'h80808080;
    tick();
    bif.in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bif.out_last) found = 1'b1;
      else tick();
    end
    chk("sum_neg_seen", 32'(found), 1);
    chk("sum_neg", 32'(out_sum), 32'(-512));
    tick();
    bif.in_valid = 1'b1;
    bif.in_data  = 32'h7F7F7F7F;
    tick();
    bif.in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bif.out_last) found = 1'b1;
      else tick();
    end
    chk("sum_pos_seen", 32'(found), 1);
    chk("sum_pos", 32'(out_sum), 32'(508));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_rx.md
STREAM_RX -- requirements
Module: stream_rx

Interface
REQ-001 Parameter N, default 4: lane count per beat; integer ≥2, power of two.
REQ-002 Parameter DEPTH, default 8: beat FIFO depth; power of two ≥2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream beat qualifier; no upstream backpressure exists.
REQ-006 in_data  input  N*8  N signed 8-bit lanes; lane i = in_data[8i+7:8i].
REQ-007 out_valid  output  1  serial lane available.
REQ-008 out_ready  input  1  downstream accepts lane when high with out_valid.
REQ-009 out_data  output  8  current signed lane.
REQ-010 out_lane  output  clog2(N)  index of current lane.
REQ-011 out_last  output  1  high with lane N-1.
REQ-012 overflow  output  1  sticky: a beat was dropped.
REQ-013 clr_ovf  input  1  synchronous clear of overflow.
REQ-014 level  output  clog2(DEPTH+1)  FIFO occupancy, 0..DEPTH; excludes the beat held by the serializer.

Function
REQ-015 Beat sampled at each rising edge with in_valid=1; written to FIFO when registered level<DEPTH.
REQ-016 Full test uses level before that edge's pop; a beat arriving while full is dropped even if a pop occurs the same edge.
REQ-017 Dropped beat sets overflow at that edge; FIFO contents and order unaffected.
REQ-018 clr_ovf=1 clears overflow next edge; a simultaneous drop keeps overflow=1 (set wins).
REQ-019 Serializer FSM states IDLE and SEND; out_valid=1 only in SEND.
REQ-020 IDLE: if level>0, pop head into serializer register, lane index=0, go SEND.
REQ-021 SEND: out_valid&&out_ready advances lane index by 1; out_data/out_lane/out_last hold stable while out_ready=0.
REQ-022 Acceptance of lane N-1: if level>0, pop next beat, index=0, stay SEND (no bubble); else go IDLE.
REQ-023 Latency: beat sampled at edge k with FIFO empty and serializer IDLE → out_valid=1 with lane 0 after edge k+1.
REQ-024 Simultaneous push and pop in one edge: level unchanged; both performed.
REQ-025 FIFO pointers wrap modulo DEPTH; beats emitted strictly in arrival order.
REQ-026 Throughput: one lane per cycle under continuous out_ready.

Reset
REQ-027 rst_n=0 asynchronously: FSM=IDLE, FIFO empty, level=0, out_valid=0, out_data=0, out_lane=0, out_last=0, overflow=0, out_sum=0 when present.
REQ-028 Reset mid-operation discards the in-flight beat and all FIFO contents; after release, first beat accepted is treated as into an empty block.

Configuration
REQ-029 Macro STREAM_RX_LANE_SUM_EN defined: extra output out_sum, width 8+clog2(N), signed = sum of all N lanes of the beat in the serializer, valid while out_last=1, computed at pop.
REQ-030 Macro undefined: out_sum port and its adder absent; all other behaviour identical.

Verification
REQ-031 N=4, DEPTH=4, out_ready=1, one beat in_data=0x807F01FF → out_data FF,01,7F,80 on consecutive cycles, out_last on 4th, first out_valid one edge after sample.
REQ-032 out_ready=0, 6 consecutive beats → beats 1–5 retained, beat 6 dropped, overflow=1, level=4; then out_ready=1 → 20 lanes of beats 1–5 in order, no bubble between beats.
REQ-033 Continuous beats every 4 cycles with out_ready toggling 1,0,1,0 → output values held while stalled, order preserved, overflow stays 0 until FIFO fills.
REQ-034 overflow=1, clr_ovf=1 on same edge as a dropped beat → overflow remains 1; clr_ovf alone next edge → overflow=0.
REQ-035 rst_n low for one cycle during SEND lane 2 with level=3 → all outputs at reset values immediately; new beat after release emitted from lane 0.
REQ-036 STREAM_RX_LANE_SUM_EN defined, beat lanes −128,−128,−128,−128 → out_sum=−512 with out_last; lanes 127×4 → out_sum=508.
